// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants and types for the register-file write-back arbiter.
// Optional feature macro: RF_WB_BYPASS_EN (adds write-in-flight forwarding ports).
package rf_wb_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned CNT_W = 4;

    localparam logic [AW-1:0] X0_ADDR = '0;

    typedef enum logic [0:0] {
        ARB_NORM    = 1'b0,
        ARB_FORCE_B = 1'b1
    } arb_state_t;

    // x0 is hardwired to zero, so a write there never reaches the array.
    function automatic logic writes_rf(input logic [AW-1:0] addr);
        return addr != X0_ADDR;
    endfunction

endpackage

// File: rtl/rf_wb_arbiter_if.sv
// Write-back bus between the two write sources, the arbiter and the register file.
// Optional feature macro: RF_WB_BYPASS_EN adds the rs1/rs2 forwarding signals.
interface rf_wb_arbiter_if;
    import rf_wb_pkg::*;

    logic            a_valid;
    logic [AW-1:0]   a_addr;
    logic [XLEN-1:0] a_data;
    logic            a_stall;
    logic            b_valid;
    logic [AW-1:0]   b_addr;
    logic [XLEN-1:0] b_data;
    logic            b_ready;
    logic            rf_regwrite;
    logic [AW-1:0]   rf_waddr;
    logic [XLEN-1:0] rf_wdata;

`ifdef RF_WB_BYPASS_EN
    logic [AW-1:0]   rs1_addr;
    logic [AW-1:0]   rs2_addr;
    logic [XLEN-1:0] rs1_rf;
    logic [XLEN-1:0] rs2_rf;
    logic [XLEN-1:0] rs1_fwd;
    logic [XLEN-1:0] rs2_fwd;

    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output rs1_addr, rs2_addr, rs1_rf, rs2_rf,
        input  a_stall, b_ready, rf_regwrite, rf_waddr, rf_wdata,
        input  rs1_fwd, rs2_fwd
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  rs1_addr, rs2_addr, rs1_rf, rs2_rf,
        output a_stall, b_ready, rf_regwrite, rf_waddr, rf_wdata,
        output rs1_fwd, rs2_fwd
    );
`else
    modport master (
        output a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        input  a_stall, b_ready, rf_regwrite, rf_waddr, rf_wdata
    );

    modport slave (
        input  a_valid, a_addr, a_data, b_valid, b_addr, b_data,
        output a_stall, b_ready, rf_regwrite, rf_waddr, rf_wdata
    );
`endif

endinterface

// File: rtl/rf_wb_starve_timer.sv
// Counts how long port B has been refused and flags when it must be force-granted.
module rf_wb_starve_timer
    import rf_wb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4  // legal range 1..15
) (
    input  logic clk,
    input  logic rst,
    input  logic b_valid,
    input  logic b_ready,
    output logic force_grant
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    logic [CNT_W-1:0] wait_cnt_d;
    logic [CNT_W-1:0] wait_cnt_q;

    // Count refused B cycles; clear on handshake or withdrawn request, saturate at MAX_WAIT.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!b_valid || b_ready) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != MAX_CNT) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    // Look ahead one cycle so B is served on exactly its MAX_WAIT-th refused cycle boundary.
    assign force_grant = (wait_cnt_d == MAX_CNT);

endmodule

// File: rtl/rf_wb_arbiter.sv
// Register-file write-port arbiter: A (pipeline WB) has priority, B (long-latency unit)
// is force-granted after MAX_WAIT refused cycles. Winning write is registered onto rf_*.
// Optional feature macro: RF_WB_BYPASS_EN adds combinational rs1/rs2 forwarding.
module rf_wb_arbiter
    import rf_wb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = 4
) (
    input  logic            clk,
    input  logic            rst,
    rf_wb_arbiter_if.slave  bus
);

    arb_state_t      state_q;
    arb_state_t      state_d;
    logic            grant_a;
    logic            grant_b;
    logic            b_ready;
    logic            a_stall;
    logic            force_grant;
    logic            rf_regwrite_q;
    logic [AW-1:0]   rf_waddr_q;
    logic [XLEN-1:0] rf_wdata_q;

    rf_wb_starve_timer #(
        .MAX_WAIT (MAX_WAIT)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .b_valid     (bus.b_valid),
        .b_ready     (b_ready),
        .force_grant (force_grant)
    );

    // Grant selection, handshake outputs and next-state; all handshakes held off during reset.
    always_comb begin
        state_d = state_q;
        grant_a = 1'b0;
        grant_b = 1'b0;
        b_ready = 1'b0;
        a_stall = 1'b0;
        unique case (state_q)
            ARB_NORM: begin
                grant_a = bus.a_valid;
                grant_b = bus.b_valid & ~bus.a_valid;
                b_ready = bus.b_valid & ~bus.a_valid;
                if (force_grant) begin
                    state_d = ARB_FORCE_B;
                end
            end
            ARB_FORCE_B: begin
                grant_b = bus.b_valid;
                grant_a = bus.a_valid & ~bus.b_valid;
                b_ready = bus.b_valid;
                a_stall = bus.a_valid & bus.b_valid;
                state_d = ARB_NORM;
            end
            default: state_d = ARB_NORM;
        endcase
        if (!rst) begin
            grant_a = 1'b0;
            grant_b = 1'b0;
            b_ready = 1'b0;
            a_stall = 1'b0;
        end
    end

    // State register and registered write port; address/data hold when nothing is granted.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ARB_NORM;
            rf_regwrite_q <= 1'b0;
            rf_waddr_q    <= '0;
            rf_wdata_q    <= '0;
        end else begin
            state_q       <= state_d;
            rf_regwrite_q <= 1'b0;
            if (grant_a) begin
                rf_regwrite_q <= writes_rf(bus.a_addr);
                rf_waddr_q    <= bus.a_addr;
                rf_wdata_q    <= bus.a_data;
            end else if (grant_b) begin
                rf_regwrite_q <= writes_rf(bus.b_addr);
                rf_waddr_q    <= bus.b_addr;
                rf_wdata_q    <= bus.b_data;
            end
        end
    end

    assign bus.b_ready     = b_ready;
    assign bus.a_stall     = a_stall;
    assign bus.rf_regwrite = rf_regwrite_q;
    assign bus.rf_waddr    = rf_waddr_q;
    assign bus.rf_wdata    = rf_wdata_q;

`ifdef RF_WB_BYPASS_EN
    // Forward the write still in flight to the register file to same-cycle readers.
    assign bus.rs1_fwd = (rf_regwrite_q && (rf_waddr_q == bus.rs1_addr) &&
                          (bus.rs1_addr != X0_ADDR)) ? rf_wdata_q : bus.rs1_rf;
    assign bus.rs2_fwd = (rf_regwrite_q && (rf_waddr_q == bus.rs2_addr) &&
                          (bus.rs2_addr != X0_ADDR)) ? rf_wdata_q : bus.rs2_rf;
`endif

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Directed bench for rf_wb_arbiter with a scoreboard of expected register-file writes.
// Honours RF_WB_BYPASS_EN when the design is built with it.
module tb_rf_wb_arbiter;
    import rf_wb_pkg::*;

    typedef struct packed {
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    wr_t  sb[$];

    always #5 clk = ~clk;

    rf_wb_arbiter_if bus();

    rf_wb_arbiter #(
        .MAX_WAIT (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic av, input logic [AW-1:0] aa, input logic [XLEN-1:0] ad,
                         input logic bv, input logic [AW-1:0] ba, input logic [XLEN-1:0] bd);
        bus.a_valid = av;
        bus.a_addr  = aa;
        bus.a_data  = ad;
        bus.b_valid = bv;
        bus.b_addr  = ba;
        bus.b_data  = bd;
    endtask

    task automatic idle();
        drive(1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [AW-1:0] addr, input logic [XLEN-1:0] data);
        sb.push_back(wr_t'{addr: addr, data: data});
    endtask

    task automatic check_hs(input string tag, input logic exp_ready, input logic exp_stall);
        check({tag, "_b_ready"}, 64'(bus.b_ready), 64'(exp_ready));
        check({tag, "_a_stall"}, 64'(bus.a_stall), 64'(exp_stall));
    endtask

    // Every write seen on the register-file port must be the oldest expected one.
    always @(negedge clk) begin
        if (rst && bus.rf_regwrite === 1'b1) begin
            check("sb_write_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                wr_t e;
                e = sb.pop_front();
                check("sb_addr", 64'(bus.rf_waddr), 64'(e.addr));
                check("sb_data", 64'(bus.rf_wdata), 64'(e.data));
            end
        end
    end

    initial begin
        idle();
`ifdef RF_WB_BYPASS_EN
        bus.rs1_addr = '0;
        bus.rs2_addr = '0;
        bus.rs1_rf   = '0;
        bus.rs2_rf   = '0;
`endif
        // Reset values.
        #12;
        check("rst_regwrite", 64'(bus.rf_regwrite), 64'd0);
        check("rst_waddr", 64'(bus.rf_waddr), 64'd0);
        check("rst_wdata", 64'(bus.rf_wdata), 64'd0);
        check_hs("rst", 1'b0, 1'b0);
        step();
        rst = 1'b1;
        #1;
        check("rst_state", 64'(dut.state_q), 64'(ARB_NORM));

        // A only.
        drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0);
        #1;
        check_hs("a_only", 1'b0, 1'b0);
        expect_wr(5'd5, 32'hDEADBEEF);
        step();
        idle();
        check("a_only_regwrite", 64'(bus.rf_regwrite), 64'd1);
        check("a_only_waddr", 64'(bus.rf_waddr), 64'd5);
        check("a_only_wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
        step();
        check("a_only_one_cycle", 64'(bus.rf_regwrite), 64'd0);
        check("no_grant_hold_addr", 64'(bus.rf_waddr), 64'd5);
        check("no_grant_hold_data", 64'(bus.rf_wdata), 64'hDEADBEEF);

        // B only: accepted in the same cycle.
        drive(1'b0, '0, '0, 1'b1, 5'd7, 32'h12);
        #1;
        check_hs("b_only", 1'b1, 1'b0);
        expect_wr(5'd7, 32'h12);
        step();
        idle();
        check("b_only_regwrite", 64'(bus.rf_regwrite), 64'd1);
        check("b_only_waddr", 64'(bus.rf_waddr), 64'd7);
        step();

        // B waits two cycles then withdraws: the wait counter must restart from zero.
        for (int i = 0; i < 2; i++) begin
            drive(1'b1, AW'(10 + i), XLEN'(32'h100 + i), 1'b1, 5'd9, 32'h99);
            #1;
            check_hs("pre_wait", 1'b0, 1'b0);
            expect_wr(AW'(10 + i), XLEN'(32'h100 + i));
            step();
        end
        drive(1'b1, 5'd12, 32'h102, 1'b0, '0, '0);
        expect_wr(5'd12, 32'h102);
        step();

        // Starvation: A streams, B is refused four cycles then force-granted.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, AW'(13 + i), XLEN'(32'h103 + i), 1'b1, 5'd9, 32'h99);
            #1;
            check_hs("starve_wait", 1'b0, 1'b0);
            expect_wr(AW'(13 + i), XLEN'(32'h103 + i));
            step();
        end
        drive(1'b1, 5'd17, 32'h117, 1'b1, 5'd9, 32'h99);
        #1;
        check_hs("starve_force", 1'b1, 1'b1);
        expect_wr(5'd9, 32'h99);
        step();
        check("starve_cnt_clear", 64'(dut.u_timer.wait_cnt_q), 64'd0);
        check("starve_back_norm", 64'(dut.state_q), 64'(ARB_NORM));
        drive(1'b1, 5'd17, 32'h117, 1'b0, '0, '0);
        #1;
        check_hs("starve_a_retry", 1'b0, 1'b0);
        expect_wr(5'd17, 32'h117);
        step();
        idle();
        step();

        // x0 targets: handshakes complete, nothing is written.
        drive(1'b1, 5'd0, 32'h55, 1'b0, '0, '0);
        #1;
        check_hs("x0_a", 1'b0, 1'b0);
        step();
        drive(1'b0, '0, '0, 1'b1, 5'd0, 32'h66);
        #1;
        check("x0_a_regwrite", 64'(bus.rf_regwrite), 64'd0);
        check_hs("x0_b", 1'b1, 1'b0);
        step();
        idle();
        check("x0_b_regwrite", 64'(bus.rf_regwrite), 64'd0);
        step();

        // Same destination from both ports: A first, then B; B's value lands last.
        drive(1'b1, 5'd6, 32'h111, 1'b1, 5'd6, 32'h222);
        #1;
        check_hs("same_reg_a", 1'b0, 1'b0);
        expect_wr(5'd6, 32'h111);
        step();
        drive(1'b0, '0, '0, 1'b1, 5'd6, 32'h222);
        #1;
        check_hs("same_reg_b", 1'b1, 1'b0);
        expect_wr(5'd6, 32'h222);
        step();
        idle();
        check("same_reg_last_wins", 64'(bus.rf_wdata), 64'h222);
        step();

        // Reset in the middle of traffic with B pending.
        drive(1'b1, 5'd20, 32'h200, 1'b1, 5'd21, 32'h210);
        #1;
        check_hs("mid_rst_pre", 1'b0, 1'b0);
        expect_wr(5'd20, 32'h200);
        step();
        drive(1'b1, 5'd22, 32'h202, 1'b1, 5'd21, 32'h210);
        expect_wr(5'd22, 32'h202);
        step();
        rst = 1'b0;
        sb.delete();  // the write in flight is discarded by reset
        #1;
        check("mid_rst_regwrite", 64'(bus.rf_regwrite), 64'd0);
        check("mid_rst_waddr", 64'(bus.rf_waddr), 64'd0);
        check_hs("mid_rst", 1'b0, 1'b0);
        check("mid_rst_cnt", 64'(dut.u_timer.wait_cnt_q), 64'd0);
        step();
        step();
        idle();
        rst = 1'b1;
        #1;
        check("post_rst_state", 64'(dut.state_q), 64'(ARB_NORM));
        drive(1'b1, 5'd23, 32'h203, 1'b1, 5'd24, 32'h240);
        #1;
        check_hs("post_rst_a", 1'b0, 1'b0);
        expect_wr(5'd23, 32'h203);
        step();
        drive(1'b0, '0, '0, 1'b1, 5'd24, 32'h240);
        #1;
        check_hs("post_rst_b", 1'b1, 1'b0);
        expect_wr(5'd24, 32'h240);
        step();
        idle();
        step();

`ifdef RF_WB_BYPASS_EN
        // Forwarding of the write in flight.
        drive(1'b1, 5'd3, 32'hA5, 1'b0, '0, '0);
        expect_wr(5'd3, 32'hA5);
        step();
        idle();
        bus.rs1_addr = 5'd3;
        bus.rs1_rf   = 32'h0;
        bus.rs2_addr = 5'd0;
        bus.rs2_rf   = 32'h77;
        #1;
        check("byp_rs1_fwd", 64'(bus.rs1_fwd), 64'hA5);
        check("byp_rs2_x0", 64'(bus.rs2_fwd), 64'h77);
        step();
        check("byp_rs1_no_write", 64'(bus.rs1_fwd), 64'h0);
`endif

        step();
        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
